// File: rtl/ram_scan_reader_if.sv
// ram_scan_reader_if: RAM read port plus the captured-word display bus.
interface ram_scan_reader_if;
  logic [4:0] rd_addr;
  logic       rd_en;
  logic [3:0] rd_q;
  logic [4:0] out_addr;
  logic [3:0] out_data;
  logic       out_valid;
  modport master(output rd_addr, rd_en, out_addr, out_data, out_valid, input rd_q);
  modport slave(input rd_addr, rd_en, out_addr, out_data, out_valid, output rd_q);
endinterface

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: walks RAM addresses 0..31, capturing each word after the 1-cycle read latency.
// Define RAM_SCAN_WRAP_EN to restart at address 0 after 31 instead of stopping in DONE.
module ram_scan_reader #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic step_mode,
  input  logic step,
  output logic busy,
  output logic done,
  ram_scan_reader_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, DONE} state_t;
  localparam logic [25:0] CNT_MAX = 26'(TICK_DIV - 1);
  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d, out_addr_q, out_addr_d;
  logic [3:0]  out_data_q, out_data_d;
  logic [25:0] cnt_q, cnt_d;
  logic        step_d_q, rd_en_q, rd_en_d, out_valid_q, out_valid_d;
  logic        busy_q, busy_d, done_q, done_d, adv;
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    adv        = 1'b0;
    case (state_q)
      IDLE:    if (start && !stop) begin state_d = ISSUE; ptr_d = '0; end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        out_addr_d = ptr_q;
        out_data_d = bus.rd_q;
        cnt_d      = '0;
        state_d    = HOLD;
      end
      HOLD: begin
        adv   = step_mode ? (step && !step_d_q) : (cnt_q == CNT_MAX);
        cnt_d = step_mode ? cnt_q : cnt_q + 26'd1;
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
`ifdef RAM_SCAN_WRAP_EN
      ptr_d   = ptr_q + 5'd1;
      state_d = ISSUE;
`else
      ptr_d   = (ptr_q == 5'd31) ? ptr_q : ptr_q + 5'd1;
      state_d = (ptr_q == 5'd31) ? DONE : ISSUE;
`endif
    end
    // stop overrides everything, including a capture in flight
    if (stop && state_q != IDLE) begin
      state_d    = IDLE;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
    end
    rd_en_d     = state_d == ISSUE;
    out_valid_d = state_q == CAPTURE && !stop;
    busy_d      = state_d == ISSUE || state_d == CAPTURE || state_d == HOLD;
    done_d      = state_d == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      step_d_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      step_d_q    <= step;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign bus.rd_addr   = ptr_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: doc/ram_scan_reader.md
# ram_scan_reader

Sequential read-out engine for the 32x4 on-chip RAM used in the memory lab. It walks every RAM address from 0 to 31 and issues one read per address, accounting for the RAM's one-cycle read latency. Each captured word and its address are presented on registered outputs, where the existing hex decoders display them. The block is the read-side counterpart to the switch-driven RAM write path: writes come from switches, and this block reads the contents back automatically or one step at a time.

## Interface
- TICK_DIV, default 50_000_000 — clock cycles spent in HOLD per address in auto mode; legal range 1 to 2^26-1.
- clock  in  1  — single system clock; all logic is on its rising edge.
- reset  in  1  — synchronous, active-high; clears all state on the next rising edge.
- start  in  1  — level; sampled only in IDLE; begins a scan at address 0.
- stop  in  1  — level; aborts any scan and returns to IDLE.
- step_mode  in  1  — 1: advance only on a step edge; 0: advance every TICK_DIV cycles.
- step  in  1  — synchronous level; the rising edge is detected internally (registered step_d).
- rd_q  in  4  — RAM read data; valid exactly one cycle after rd_en=1.
- rd_addr  out  5  — RAM read address.
- rd_en  out  1  — one-cycle read strobe (gates the RAM wren-low read port / display path).
- out_addr  out  5  — address of the last captured word.
- out_data  out  4  — last captured word.
- out_valid  out  1  — one-cycle pulse when out_addr/out_data update.
- busy  out  1  — 1 in ISSUE, CAPTURE, HOLD.
- done  out  1  — 1 in DONE.

## Operation
- States: IDLE, ISSUE, CAPTURE, HOLD, DONE.
- IDLE: if start=1 and stop=0, go to ISSUE and set scan address ptr=0. Otherwise stay.
- ISSUE: rd_en=1, rd_addr=ptr; always go to CAPTURE.
- CAPTURE: register out_data<=rd_q and out_addr<=ptr, pulse out_valid, clear the hold counter, go to HOLD.
- HOLD, step_mode=0: count up; when count reaches TICK_DIV-1, advance.
- HOLD, step_mode=1: advance on a detected step rising edge. The counter is frozen while in step mode. Switching mode mid-HOLD resumes the count from its held value.
- Advance when ptr<31: ptr<=ptr+1, go to ISSUE.
- Advance when ptr=31: see Configuration.
- DONE: done=1, outputs hold their last values. Leave to IDLE when start=0 or stop=1.
- stop=1 in any state except IDLE: next state IDLE. out_addr/out_data are retained; rd_en=0.
- start asserted while busy: ignored.
- start and stop both 1 in IDLE: stay in IDLE.
- Arithmetic: ptr is 5-bit; the hold counter is 26-bit unsigned; no signed math.

## Timing
- Reset values: state=IDLE; ptr, rd_addr, out_addr, out_data = 0; rd_en, out_valid, busy, done, step_d = 0.
- Reset mid-scan: IDLE with reset values on the next edge. Reset has priority over stop, and stop over start and step.
- Start at edge N (IDLE): ISSUE during cycle N+1 (rd_en=1). CAPTURE during N+2. out_valid=1 and new out_data/out_addr visible during N+3.
- Auto mode address-to-address period: TICK_DIV+2 cycles.
- Step mode: a step edge sampled at edge M gives ISSUE in M+1 and out_valid in M+3. Step edges outside HOLD are dropped, not queued.
- rd_en is never high for two consecutive cycles.

## Configuration
- RAM_SCAN_WRAP_EN defined: advance at ptr=31 sets ptr<=0 and goes to ISSUE. The scan repeats until stop or reset, and done never asserts.
- RAM_SCAN_WRAP_EN undefined: advance at ptr=31 goes to DONE.

## Test plan
- Reset then idle: hold reset 2 cycles, then release with start=0 → all outputs 0; rd_en stays 0 for 20 cycles.
- Auto scan, TICK_DIV=4, RAM preloaded with data=addr[3:0]^4'hA, wrap off, start held → 32 out_valid pulses spaced 6 cycles apart; out_addr 0..31 with matching data; done=1 after addr 31; busy=0.
- Latency check: start rises at edge N → rd_en=1 only in cycle N+1, and out_valid in cycle N+3 with out_addr=0.
- Step mode: step_mode=1, step held high 10 cycles three times → exactly 3 more captures (addr 1, 2, 3); no capture while step stays high.
- Stop mid-scan at addr 7 → IDLE next edge, out_addr stays 7, busy=0; a new start restarts at addr 0.
- Wrap build (RAM_SCAN_WRAP_EN), TICK_DIV=1 → after addr 31, next out_valid has out_addr=0; done stays 0 over 70 captures.
